// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// the address-region enum and the address decoder.
package dmem_pkg;

   // Byte offsets of the MMIO registers relative to the MMIO window base.
   localparam logic [31:0] GPIO_OFS   = 32'h0000_0000;
   localparam logic [31:0] CYC_LO_OFS = 32'h0000_0004;
   localparam logic [31:0] CYC_HI_OFS = 32'h0000_0008;
   localparam logic [31:0] DBG_TX_OFS = 32'h0000_000C;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_GPIO,
      REG_CYC_LO,
      REG_CYC_HI,
      REG_DBG,
      REG_ILLEGAL
   } region_e;

   // Map a byte address to the region it hits. Misaligned addresses and
   // addresses outside RAM and the four MMIO registers are illegal.
   function automatic region_e decode(input logic [31:0] addr,
                                      input logic [31:0] mmio_base,
                                      input logic [31:0] ram_bytes);
      region_e     r;
      logic [31:0] ofs;
      ofs = addr - mmio_base;
      r   = REG_ILLEGAL;
      if (addr[1:0] != 2'b00)     r = REG_ILLEGAL;
      else if (addr < ram_bytes)  r = REG_RAM;
      else if (ofs == GPIO_OFS)   r = REG_GPIO;
      else if (ofs == CYC_LO_OFS) r = REG_CYC_LO;
      else if (ofs == CYC_HI_OFS) r = REG_CYC_HI;
      else if (ofs == DBG_TX_OFS) r = REG_DBG;
      return r;
   endfunction

endpackage

// File: rtl/data_mem_responder_dbg_tx_fifo.sv
// Debug-TX byte FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable. The head entry is kept in its own register so
// the consumer sees a glitch-free byte that is zero whenever the FIFO is empty.
module dbg_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             dropped
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr, rd_ptr;
   logic [PW:0]      wr_next, rd_next;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // accepted when it coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dropped = push && !do_push;
   assign wr_next = wr_ptr + (PW+1)'(do_push);
   assign rd_next = rd_ptr + (PW+1)'(do_pop);
   assign head    = head_q;

   // Work out the head byte that will be visible after this cycle's push/pop.
   always_comb begin
      // NOTE: every signal written here gets a default first, otherwise a path
      // that skips the assignment would infer a latch.
      head_d = head_q;
      if (rd_next == wr_next) begin
         head_d = '0;
      end else if (do_pop) begin
         if ((rd_ptr + 1'b1) == wr_ptr) head_d = push_data;
         else                           head_d = mem[rd_next[PW-1:0]];
      end else if (empty) begin
         head_d = push_data;
      end
   end

   // Pointer and head registers.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head_q <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         head_q <= head_d;
      end
   end

   // Storage array; suppressed while reset is asserted so an aborted push leaves no trace.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are deliberately not reset; the pointers define
      // which entries are meaningful, and a reset would block RAM inference.
      if (do_push && rstn) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding a GPIO register,
// a free-running 64-bit cycle counter with a high-word snapshot, and the
// debug-TX FIFO. Loads return one cycle after the request; stores commit at
// the request edge. Illegal requests change nothing and pulse o_bus_err.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] i_data_mem_addr,
   input  logic [31:0] i_data_mem_write_data,
   input  logic        i_data_mem_read_en,
   input  logic        i_data_mem_write_en,
   output logic [31:0] o_data_mem_read_data,
   output logic        o_bus_err,
   output logic [31:0] o_gpio,
   output logic [7:0]  o_dbg_tx_data,
   output logic        o_dbg_tx_valid,
   input  logic        i_dbg_tx_ready
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

   logic [31:0] ram [DEPTH_WORDS];
   logic [AW-1:0] ram_idx;

   region_e     region;
   logic        req, illegal, acc_ok;
   logic        ram_we, gpio_we, fifo_push, lo_capture;
   logic [31:0] rd_mux;

   logic [31:0] read_data_q;
   logic        bus_err_q;
   logic [31:0] gpio_q;
   logic [63:0] cycle_cnt;
   logic [31:0] hi_snap;

   logic        fifo_full, fifo_empty, fifo_dropped;

   assign ram_idx = i_data_mem_addr[AW+1:2];

   // Decode the request and select the read source from pre-edge state, which
   // gives read-before-write ordering for simultaneous read and write.
   always_comb begin
      region     = decode(i_data_mem_addr, MMIO_BASE, RAM_BYTES);
      req        = i_data_mem_read_en || i_data_mem_write_en;
      illegal    = (region == REG_ILLEGAL) ||
                   (i_data_mem_write_en && (region == REG_CYC_LO || region == REG_CYC_HI));
      acc_ok     = req && !illegal;
      ram_we     = acc_ok && i_data_mem_write_en && (region == REG_RAM);
      gpio_we    = acc_ok && i_data_mem_write_en && (region == REG_GPIO);
      fifo_push  = acc_ok && i_data_mem_write_en && (region == REG_DBG);
      lo_capture = acc_ok && i_data_mem_read_en  && (region == REG_CYC_LO);
      rd_mux     = '0;
      case (region)
         REG_RAM:    rd_mux = ram[ram_idx];
         REG_GPIO:   rd_mux = gpio_q;
         REG_CYC_LO: rd_mux = cycle_cnt[31:0];
         REG_CYC_HI: rd_mux = hi_snap;
         REG_DBG:    rd_mux = {30'b0, fifo_full, fifo_empty};
         default:    rd_mux = '0;
      endcase
   end

   // RAM write port; held off during reset so an interrupted store writes nothing.
   always_ff @(posedge clk) begin
      if (ram_we && rstn) ram[ram_idx] <= i_data_mem_write_data;
   end

   // Load data, error pulse, GPIO, cycle counter and high-word snapshot.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         read_data_q <= '0;
         bus_err_q   <= 1'b0;
         gpio_q      <= '0;
         cycle_cnt   <= '0;
         hi_snap     <= '0;
      end else begin
         if (i_data_mem_read_en) read_data_q <= illegal ? 32'h0 : rd_mux;
         bus_err_q <= (req && illegal) || fifo_dropped;
         if (gpio_we)    gpio_q  <= i_data_mem_write_data;
         if (lo_capture) hi_snap <= cycle_cnt[63:32];
         cycle_cnt <= cycle_cnt + 64'd1;
      end
   end

   dbg_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_dbg_tx_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (i_data_mem_write_data[7:0]),
      .pop       (i_dbg_tx_ready),
      .head      (o_dbg_tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .dropped   (fifo_dropped)
   );

   assign o_data_mem_read_data = read_data_q;
   assign o_bus_err            = bus_err_q;
   assign o_gpio               = gpio_q;
   assign o_dbg_tx_valid       = !fifo_empty;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Load responses and bus-error pulses
// are predicted into a scoreboard when a request is driven and compared one
// cycle later; transmitted bytes are predicted into a second queue.
module tb_data_mem_responder;

   localparam logic [31:0] MB = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] addr, wdata;
   logic        re, we;
   logic [31:0] rd;
   logic        bus_err;
   logic [31:0] gpio;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      logic        chk_rd;
      string       tag;
   } exp_t;

   exp_t         sb[$];
   logic [7:0]   tx_exp[$];
   int           n_total = 0;
   int           n_pass  = 0;
   int           n_fail  = 0;
   longint unsigned mdl_cnt;

   data_mem_responder #(
      .DEPTH_WORDS (1024),
      .FIFO_DEPTH  (8),
      .MMIO_BASE   (MB)
   ) dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .i_data_mem_addr       (addr),
      .i_data_mem_write_data (wdata),
      .i_data_mem_read_en    (re),
      .i_data_mem_write_en   (we),
      .o_data_mem_read_data  (rd),
      .o_bus_err             (bus_err),
      .o_gpio                (gpio),
      .o_dbg_tx_data         (tx_data),
      .o_dbg_tx_valid        (tx_valid),
      .i_dbg_tx_ready        (tx_ready)
   );

   always #5 clk = ~clk;

   // Reference cycle counter: zero in reset, +1 on every edge afterwards.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) mdl_cnt <= 0;
      else       mdl_cnt <= mdl_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare the DUT response to the oldest outstanding prediction.
   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         if (e.chk_rd) chk({e.tag, "/rd"}, rd, e.rd);
         chk({e.tag, "/err"}, {31'b0, bus_err}, {31'b0, e.err});
      end
   endtask

   // Drive one request for a cycle (called at a negedge), then check its response.
   task automatic req(input logic [31:0] a, input logic [31:0] w, input logic r,
                      input logic wr, input logic [31:0] erd, input logic eerr,
                      input string tag);
      addr = a; wdata = w; re = r; we = wr;
      sb.push_back('{erd, eerr, r, tag});
      @(negedge clk);
      re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      pop_check();
   endtask

   initial begin
      int cycles;
      rstn = 1'b0; addr = '0; wdata = '0; re = 1'b0; we = 1'b0; tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rd",       rd,                 32'h0);
      chk("rst_err",      {31'b0, bus_err},   32'h0);
      chk("rst_gpio",     gpio,               32'h0);
      chk("rst_valid",    {31'b0, tx_valid},  32'h0);
      chk("rst_txdata",   {24'b0, tx_data},   32'h0);
      rstn = 1'b1;

      // Counter after ten edges out of reset.
      repeat (10) @(posedge clk);
      @(negedge clk);
      req(MB + 32'h4, 0, 1, 0, mdl_cnt[31:0], 0, "cyc_lo_10");

      // RAM round trip and read-before-write.
      req(32'h10, 32'hDEAD_BEEF, 0, 1, 0, 0, "ram_wr");
      req(32'h10, 32'h0, 1, 0, 32'hDEAD_BEEF, 0, "ram_rd");
      req(32'h20, 32'h1, 0, 1, 0, 0, "rbw_init");
      req(32'h20, 32'h2, 1, 1, 32'h1, 0, "rbw_old");
      req(32'h20, 32'h0, 1, 0, 32'h2, 0, "rbw_new");
      @(negedge clk);
      chk("rd_hold", rd, 32'h2);

      // GPIO write and read-before-write.
      req(MB, 32'h0000_5A5A, 0, 1, 0, 0, "gpio_wr");
      chk("gpio_out", gpio, 32'h0000_5A5A);
      req(MB, 32'h0000_00A5, 1, 1, 32'h0000_5A5A, 0, "gpio_rbw");
      chk("gpio_out2", gpio, 32'h0000_00A5);

      // Error cases.
      req(32'h13, 0, 1, 0, 32'h0, 1, "misalign");
      @(negedge clk);
      chk("err_one_cycle", {31'b0, bus_err}, 32'h0);
      req(MB + 32'h4, 32'h1234_5678, 0, 1, 0, 1, "wr_ro");
      req(MB + 32'h4, 0, 1, 0, mdl_cnt[31:0], 0, "cyc_after_wr_ro");
      req(MB + 32'h40, 0, 1, 0, 32'h0, 1, "unmapped");
      req(32'h13, 32'hFFFF_FFFF, 0, 0, 0, 0, "idle_noerr");

      // Counter wrap and high-word snapshot.
      force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cycle_cnt;
      req(MB + 32'h4, 0, 1, 0, 32'hFFFF_FFFF, 0, "cyc_lo_max");
      req(MB + 32'h8, 0, 1, 0, 32'hFFFF_FFFF, 0, "cyc_hi_snap");
      req(MB + 32'h4, 0, 1, 0, 32'h1, 0, "cyc_wrapped");
      req(MB + 32'h8, 0, 1, 0, 32'h0, 0, "cyc_hi_after_wrap");

      // FIFO fill with the consumer stalled; the ninth push is dropped.
      req(MB + 32'hC, 0, 1, 0, 32'h1, 0, "status_empty");
      for (int i = 0; i < 8; i++) begin
         req(MB + 32'hC, 32'h41 + i, 0, 1, 0, 0, "push");
         tx_exp.push_back(8'(8'h41 + i));
      end
      req(MB + 32'hC, 32'h49, 0, 1, 0, 1, "push_full");
      req(MB + 32'hC, 0, 1, 0, 32'h2, 0, "status_full");
      chk("head_stable", {24'b0, tx_data}, 32'h41);

      // Drain in order; a push coinciding with a pop while full is accepted.
      tx_ready = 1'b1;
      chk("head_first", {24'b0, tx_data}, {24'b0, tx_exp.pop_front()});
      req(MB + 32'hC, 32'h49, 0, 1, 0, 0, "push_pop_full");
      tx_exp.push_back(8'h49);
      cycles = 0;
      while (tx_exp.size() > 0 && cycles < 20) begin
         chk("drain_valid", {31'b0, tx_valid}, 32'h1);
         chk("drain_data", {24'b0, tx_data}, {24'b0, tx_exp.pop_front()});
         @(negedge clk);
         cycles++;
      end
      chk("drain_cycles", cycles, 32'd8);
      chk("drain_valid_low", {31'b0, tx_valid}, 32'h0);
      chk("drain_data_zero", {24'b0, tx_data}, 32'h0);

      // Push while empty with ready high: push only, byte appears then drains.
      req(MB + 32'hC, 32'h60, 0, 1, 0, 0, "push_empty_ready");
      chk("empty_push_valid", {31'b0, tx_valid}, 32'h1);
      chk("empty_push_data", {24'b0, tx_data}, 32'h60);
      @(negedge clk);
      chk("empty_push_drained", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      req(MB + 32'hC, 0, 1, 0, 32'h1, 0, "status_empty2");

      // Asynchronous reset with FIFO contents and GPIO set.
      for (int i = 0; i < 3; i++) req(MB + 32'hC, 32'h70 + i, 0, 1, 0, 0, "push3");
      req(MB, 32'hA5, 0, 1, 0, 0, "gpio_a5");
      chk("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
      req(MB + 32'h8, 0, 1, 0, 32'h0, 0, "pre_rst_rd");
      req(32'h10, 0, 1, 0, 32'hDEAD_BEEF, 0, "pre_rst_rd2");
      #2 rstn = 1'b0;
      #1;
      chk("arst_rd",     rd,                32'h0);
      chk("arst_gpio",   gpio,              32'h0);
      chk("arst_valid",  {31'b0, tx_valid}, 32'h0);
      chk("arst_txdata", {24'b0, tx_data},  32'h0);
      chk("arst_err",    {31'b0, bus_err},  32'h0);
      @(negedge clk);
      rstn = 1'b1;
      req(MB + 32'hC, 0, 1, 0, 32'h1, 0, "post_rst_status");
      req(32'h10, 0, 1, 0, 32'hDEAD_BEEF, 0, "ram_kept");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
